// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32 subset datapath (load/store/OP-IMM/R/branch).
// Optional PERF_COUNTERS_EN adds CycleCount/InstrCount retire and cycle counters.
module multicycle_control #(
  parameter int RESET_STATE_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               Opcode,
  input  logic                     Zero,
  input  logic                     MemReady,
  output logic                     PCWrite,
  output logic                     IRWrite,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic                     RegWrite,
  output logic                     MemtoReg,
  output logic                     ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [1:0]               ALUOp,
  output logic                     PCSource,
  output logic                     Illegal,
  output logic [RESET_STATE_W-1:0] State
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]              CycleCount,
  output logic [31:0]              InstrCount
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [RESET_STATE_W-1:0] {
    S_RESET  = RESET_STATE_W'(0),
    S_FETCH  = RESET_STATE_W'(1),
    S_DECODE = RESET_STATE_W'(2),
    S_MEMADR = RESET_STATE_W'(3),
    S_MEMRD  = RESET_STATE_W'(4),
    S_MEMWB  = RESET_STATE_W'(5),
    S_MEMWR  = RESET_STATE_W'(6),
    S_EXEC   = RESET_STATE_W'(7),
    S_ALUWB  = RESET_STATE_W'(8),
    S_BRANCH = RESET_STATE_W'(9)
  } state_t;

  state_t state, next_state;
  logic   illegal_op;

  assign illegal_op = !(Opcode == OP_LOAD || Opcode == OP_STORE || Opcode == OP_IMM ||
                        Opcode == OP_REG  || Opcode == OP_BRANCH);
  assign State = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= next_state;
  end

  // Sticky: only reset clears it, so software can notice a bad opcode long after it went by.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  Illegal <= 1'b0;
    else if (state == S_DECODE && illegal_op)   Illegal <= 1'b1;
  end

  always_comb begin
    next_state = S_FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSource   = 1'b0;
    case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        // OldPC + imm precomputed into ALUOut for a possible branch
        ALUSrcB = 2'b10;
        if (Opcode == OP_LOAD || Opcode == OP_STORE) next_state = S_MEMADR;
        else if (Opcode == OP_IMM || Opcode == OP_REG) next_state = S_EXEC;
        else if (Opcode == OP_BRANCH)                  next_state = S_BRANCH;
        else                                           next_state = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead    = 1'b1;
        next_state = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        next_state = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        ALUSrcB    = (Opcode == OP_IMM) ? 2'b10 : 2'b00;
        next_state = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 1'b1;
        PCWrite  = Zero;
      end
      default: next_state = S_FETCH;
    endcase
  end

`ifdef PERF_COUNTERS_EN
  logic retire;
  assign retire = (next_state == S_FETCH) &&
                  (state == S_MEMWB || state == S_ALUWB || state == S_BRANCH || state == S_MEMWR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      CycleCount <= '0;
      InstrCount <= '0;
    end else begin
      if (state != S_RESET) CycleCount <= CycleCount + 32'd1;
      if (retire)           InstrCount <= InstrCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Random instruction-stream bench for multicycle_control; expected per-cycle traces are
// built per instruction class from the cycle-by-cycle behaviour of each instruction.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       Zero, MemReady;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, ALUSrcA, PCSource, Illegal;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] State;
`ifdef PERF_COUNTERS_EN
  logic [31:0] CycleCount, InstrCount;
`endif
  logic [11:0] obs;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, OPI = 7'b0010011,
                         OPR = 7'b0110011, BR = 7'b1100011;

  multicycle_control #(.RESET_STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .Illegal(Illegal), .State(State)
`ifdef PERF_COUNTERS_EN
    , .CycleCount(CycleCount), .InstrCount(InstrCount)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg,
                ALUSrcA, ALUSrcB, ALUOp, PCSource};

  typedef struct {
    int          st;
    bit          mr;
    bit          z;
    logic [6:0]  op;
    logic [11:0] outs;
    bit          ill;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   ill_m = 0;
  logic [6:0] bad_ops [6] = '{7'h7f, 7'h37, 7'h17, 7'h6f, 7'h00, 7'h73};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ov(bit pcw, bit irw, bit mrd, bit mwr, bit rw, bit m2r,
                                      bit asa, logic [1:0] asb, logic [1:0] aop, bit pcs);
    return {pcw, irw, mrd, mwr, rw, m2r, asa, asb, aop, pcs};
  endfunction

  task automatic add(input int st, input bit mr, input bit z, input logic [6:0] op,
                     input logic [11:0] o);
    rec_t r;
    r.st = st; r.mr = mr; r.z = z; r.op = op; r.outs = o; r.ill = ill_m;
    q.push_back(r);
  endtask

  // One instruction: wf wait cycles in FETCH, wm wait cycles in the memory-data state.
  task automatic push_instr(input logic [6:0] op, input int wf, input int wm, input bit z);
    for (int i = 0; i < wf; i++) add(1, 0, $urandom, op, ov(0,0,1,0,0,0,0,2'b01,2'b00,0));
    add(1, 1, $urandom, op, ov(1,1,1,0,0,0,0,2'b01,2'b00,0));
    add(2, $urandom, $urandom, op, ov(0,0,0,0,0,0,0,2'b10,2'b00,0));
    case (op)
      LW: begin
        add(3, $urandom, $urandom, op, ov(0,0,0,0,0,0,1,2'b10,2'b00,0));
        for (int i = 0; i < wm; i++) add(4, 0, $urandom, op, ov(0,0,1,0,0,0,0,2'b00,2'b00,0));
        add(4, 1, $urandom, op, ov(0,0,1,0,0,0,0,2'b00,2'b00,0));
        add(5, $urandom, $urandom, op, ov(0,0,0,0,1,1,0,2'b00,2'b00,0));
      end
      SW: begin
        add(3, $urandom, $urandom, op, ov(0,0,0,0,0,0,1,2'b10,2'b00,0));
        for (int i = 0; i < wm; i++) add(6, 0, $urandom, op, ov(0,0,0,1,0,0,0,2'b00,2'b00,0));
        add(6, 1, $urandom, op, ov(0,0,0,1,0,0,0,2'b00,2'b00,0));
      end
      OPI, OPR: begin
        add(7, $urandom, $urandom, op, ov(0,0,0,0,0,0,1,(op == OPI) ? 2'b10 : 2'b00,2'b10,0));
        add(8, $urandom, $urandom, op, ov(0,0,0,0,1,0,0,2'b00,2'b00,0));
      end
      BR: add(9, $urandom, z, op, ov(z,0,0,0,0,0,1,2'b00,2'b01,1));
      default: ill_m = 1;
    endcase
  endtask

  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      MemReady = r.mr; Zero = r.z; Opcode = r.op;
      #1;
      chk("state", 32'(State), 32'(r.st));
      chk("outs", 32'(obs), 32'(r.outs));
      chk("illegal", 32'(Illegal), 32'(r.ill));
    end
  endtask

  initial begin
    logic [6:0] op;
    reset = 1'b1; MemReady = 1'b0; Zero = 1'b0; Opcode = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(State), 0);
    chk("rst_outs", 32'(obs), 0);
    chk("rst_illegal", 32'(Illegal), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state_idle", 32'(State), 0);
    chk("reset_outs_idle", 32'(obs), 0);

`ifdef PERF_COUNTERS_EN
    push_instr(LW, 0, 0, 0);
    push_instr(SW, 0, 0, 0);
    push_instr(OPI, 0, 0, 0);
    push_instr(BR, 0, 0, 1);
    push_instr(7'h7f, 0, 0, 0);
    run_q();
    @(posedge clk); #1;
    chk("instr_count", InstrCount, 32'd4);
    chk("cycle_count", CycleCount, 32'd18);
`endif

    // directed walk through every instruction class and the wait paths
    push_instr(LW, 0, 0, 0);
    push_instr(SW, 0, 3, 0);
    push_instr(OPI, 0, 0, 0);
    push_instr(OPR, 0, 0, 0);
    push_instr(BR, 0, 0, 1);
    push_instr(BR, 0, 0, 0);
    push_instr(7'h7f, 0, 0, 0);
    push_instr(LW, 2, 1, 0);
    run_q();

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: op = LW;
        1: op = SW;
        2: op = OPI;
        3: op = OPR;
        4: op = BR;
        default: op = bad_ops[$urandom_range(0, 5)];
      endcase
      push_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end
    run_q();

    // asynchronous reset in the middle of a MEMRD wait
    push_instr(LW, 0, 5, 0);
    while (q.size() > 4) void'(q.pop_back());
    run_q();
    #2 reset = 1'b1;
    #1;
    chk("midrst_state", 32'(State), 0);
    chk("midrst_outs", 32'(obs), 0);
    chk("midrst_illegal", 32'(Illegal), 0);
    @(negedge clk);
    reset = 1'b0; ill_m = 0;
    #1;
    chk("post_rst_state", 32'(State), 0);
    push_instr(LW, 0, 0, 0);
    push_instr(OPR, 1, 0, 0);
    run_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
